// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: bundles the CPU request/response channel and the word-wide
// 4-phase memory bus (addr/data/ren/wen/ack) seen by mem_bus_master.
// The master modport is the initiator; the slave modport is the CPU/responder side.
interface mem_bus_master_if;
  // CPU load/store request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // CPU completion
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Memory bus
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ren;
  logic        bus_wen;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output bus_addr, bus_wdata, bus_ren, bus_wen,
    input  bus_ack, bus_rdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  bus_addr, bus_wdata, bus_ren, bus_wen,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side initiator for the word-wide 4-phase memory bus.
// One load/store at a time; sign/zero extension on loads; sub-word stores are
// done as read-modify-write because the bus only writes whole words.
// Optional feature: define MEM_MASTER_TIMEOUT_EN to abandon a strobe that has
// waited TIMEOUT_CYCLES cycles for bus_ack and complete with resp_err=1.
module mem_bus_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  mem_bus_master_if.master mbus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACKLOW = 3'd1;
  localparam logic [2:0] RD_REQ = 3'd2;
  localparam logic [2:0] RD_REL = 3'd3;
  localparam logic [2:0] MERGE  = 3'd4;
  localparam logic [2:0] WR_REQ = 3'd5;
  localparam logic [2:0] WR_REL = 3'd6;
  localparam logic [2:0] RESP   = 3'd7;

  logic [2:0]  state_reg, state_next;
  logic        req_ready_reg;
  logic        bus_ren_reg, bus_wen_reg;
  logic        we_reg, signed_reg, err_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [31:0] rdata_word_reg, bus_wdata_reg;

  logic        accept, misaligned, timeout_hit;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext, store_rep, merged_word;
  logic [3:0]  lane_en;

  assign accept = mbus.req_valid && req_ready_reg;

  // Alignment check on the incoming request (size 11 behaves as a word)
  always_comb begin
    misaligned = 1'b0;
    if (mbus.req_size == 2'b01) begin
      misaligned = mbus.req_addr[0];
    end else if (mbus.req_size[1]) begin
      misaligned = |mbus.req_addr[1:0];
    end
  end

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             in_req;

  assign in_req      = (state_reg == RD_REQ) || (state_reg == WR_REQ);
  assign timeout_hit = in_req && !mbus.bus_ack &&
                       (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent holding the current strobe; restarts on every entry to a REQ state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (in_req && (state_next == state_reg)) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Transaction sequencing
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = misaligned ? RESP : ACKLOW;
      // A stale ack from the previous transaction must clear before any strobe rises
      ACKLOW: if (!mbus.bus_ack) state_next = (we_reg && size_reg[1]) ? WR_REQ : RD_REQ;
      RD_REQ: begin
        if (mbus.bus_ack)     state_next = RD_REL;
        else if (timeout_hit) state_next = RESP;
      end
      RD_REL: if (!mbus.bus_ack) state_next = we_reg ? MERGE : RESP;
      MERGE:  state_next = WR_REQ;
      WR_REQ: begin
        if (mbus.bus_ack)     state_next = WR_REL;
        else if (timeout_hit) state_next = RESP;
      end
      WR_REL: if (!mbus.bus_ack) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State plus registered strobes/ready, all derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b0;
      bus_ren_reg   <= 1'b0;
      bus_wen_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next == IDLE);
      bus_ren_reg   <= (state_next == RD_REQ);
      bus_wen_reg   <= (state_next == WR_REQ);
    end
  end

  // Request capture, read-word latch and write-word staging
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      we_reg         <= 1'b0;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      err_reg        <= 1'b0;
      rdata_word_reg <= '0;
      bus_wdata_reg  <= '0;
    end else begin
      if (accept) begin
        addr_reg   <= mbus.req_addr;
        wdata_reg  <= mbus.req_wdata;
        we_reg     <= mbus.req_we;
        size_reg   <= mbus.req_size;
        signed_reg <= mbus.req_signed;
        err_reg    <= misaligned;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
      if ((state_reg == RD_REQ) && mbus.bus_ack) begin
        rdata_word_reg <= mbus.bus_rdata;
      end
      if ((state_reg == ACKLOW) && !mbus.bus_ack && we_reg && size_reg[1]) begin
        bus_wdata_reg <= wdata_reg;
      end
      if (state_reg == MERGE) begin
        bus_wdata_reg <= merged_word;
      end
    end
  end

  // Load lane selection and extension (little-endian lanes)
  always_comb begin
    lane_byte = rdata_word_reg[{addr_reg[1:0], 3'b000} +: 8];
    lane_half = addr_reg[1] ? rdata_word_reg[31:16] : rdata_word_reg[15:0];
    if (size_reg[1]) begin
      load_ext = rdata_word_reg;
    end else if (size_reg[0]) begin
      load_ext = {{16{signed_reg & lane_half[15]}}, lane_half};
    end else begin
      load_ext = {{24{signed_reg & lane_byte[7]}}, lane_byte};
    end
  end

  // Store lane enables and store data replicated onto every lane
  always_comb begin
    lane_en   = 4'b1111;
    store_rep = wdata_reg;
    if (!size_reg[1]) begin
      if (size_reg[0]) begin
        lane_en   = addr_reg[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{wdata_reg[15:0]}};
      end else begin
        lane_en   = 4'b0001 << addr_reg[1:0];
        store_rep = {4{wdata_reg[7:0]}};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = lane_en[gi] ? store_rep[8*gi +: 8]
                                                  : rdata_word_reg[8*gi +: 8];
    end
  endgenerate

  assign mbus.req_ready  = req_ready_reg;
  assign mbus.resp_valid = (state_reg == RESP);
  assign mbus.resp_err   = (state_reg == RESP) && err_reg;
  assign mbus.resp_rdata = ((state_reg == RESP) && !err_reg && !we_reg) ? load_ext : 32'h0;
  assign mbus.bus_addr   = {addr_reg[31:2], 2'b00};
  assign mbus.bus_wdata  = bus_wdata_reg;
  assign mbus.bus_ren    = bus_ren_reg;
  assign mbus.bus_wen    = bus_wen_reg;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed test of mem_bus_master with a simple memory
// responder (ack two cycles after a strobe) and a bus protocol monitor.
// The timeout scenario runs only when MEM_MASTER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_bus_master;
  localparam int TMO       = 8;
  localparam int ACK_DELAY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mem_bus_master_if mif();

  mem_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .mbus(mif)
  );

  always #5 clk = ~clk;

  // Responder state driven by the stimulus
  logic [31:0] mem_word = 32'h0;
  logic        mute     = 1'b0;
  logic        hold_ack = 1'b0;
  logic [31:0] wr_word  = 32'h0;
  int          dly      = 0;

  // Memory responder: acks ACK_DELAY cycles after a strobe, drops ack once strobes fall
  always @(posedge clk) begin
    if (rst) begin
      mif.bus_ack   <= 1'b0;
      mif.bus_rdata <= 32'h0;
      dly           <= 0;
    end else if (hold_ack) begin
      mif.bus_ack <= 1'b1;
    end else if (!(mif.bus_ren || mif.bus_wen)) begin
      mif.bus_ack <= 1'b0;
      dly         <= 0;
    end else if (!mute && !mif.bus_ack) begin
      if (dly == ACK_DELAY - 1) begin
        mif.bus_ack <= 1'b1;
        dly         <= 0;
        if (mif.bus_ren) mif.bus_rdata <= mem_word;
        if (mif.bus_wen) wr_word       <= mif.bus_wdata;
      end else begin
        dly <= dly + 1;
      end
    end
  end

  // Bus monitor: strobe pulses, overlap, strobe rising under ack
  logic        ren_d = 1'b0, wen_d = 1'b0;
  int          ren_pulses = 0, wen_pulses = 0, ren_hi = 0;
  logic        overlap = 1'b0, rise_on_ack = 1'b0;
  logic [31:0] ren_addr = 32'h0, wen_data = 32'h0;

  always @(posedge clk) begin
    ren_d <= mif.bus_ren;
    wen_d <= mif.bus_wen;
    if (mif.bus_ren && mif.bus_wen) overlap <= 1'b1;
    if (mif.bus_ren) ren_hi <= ren_hi + 1;
    if (mif.bus_ren && !ren_d) begin
      ren_pulses <= ren_pulses + 1;
      ren_addr   <= mif.bus_addr;
      if (mif.bus_ack) rise_on_ack <= 1'b1;
    end
    if (mif.bus_wen && !wen_d) begin
      wen_pulses <= wen_pulses + 1;
      wen_data   <= mif.bus_wdata;
      if (mif.bus_ack) rise_on_ack <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request and return after the accepting edge
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!mif.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mif.req_ready) check("ready_timeout", {31'b0, mif.req_ready}, 32'd1);
    mif.req_valid  = 1'b1;
    mif.req_we     = we;
    mif.req_size   = sz;
    mif.req_signed = sg;
    mif.req_addr   = a;
    mif.req_wdata  = wd;
    @(posedge clk);
    #1;
    mif.req_valid = 1'b0;
  endtask

  // Wait for resp_valid; cyc counts the accept cycle as cycle 1
  task automatic wait_resp(output logic [31:0] rd, output logic er, output int cyc);
    logic got;
    got = 1'b0;
    rd  = 32'h0;
    er  = 1'b0;
    cyc = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (mif.resp_valid) begin
        got = 1'b1;
        rd  = mif.resp_rdata;
        er  = mif.resp_err;
      end
    end
    if (!got) begin
      check("resp_timeout", {31'b0, got}, 32'd1);
    end else begin
      @(negedge clk);
      check("resp_one_cycle", {31'b0, mif.resp_valid}, 32'd0);
    end
  endtask

  task automatic run_txn(input string name, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int cyc,
                         output int rn, output int wn);
    int r0, w0;
    r0 = ren_pulses;
    w0 = wen_pulses;
    issue(we, sz, sg, a, wd);
    wait_resp(rd, er, cyc);
    rn = ren_pulses - r0;
    wn = wen_pulses - w0;
    $display("[TB] txn %s we=%0b size=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b cycles=%0d ren=%0d wen=%0d",
             name, we, sz, a, wd, rd, er, cyc, rn, wn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc, rn, wn, n, h0;

    mif.req_valid  = 1'b0;
    mif.req_we     = 1'b0;
    mif.req_size   = 2'b00;
    mif.req_signed = 1'b0;
    mif.req_addr   = 32'h0;
    mif.req_wdata  = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",      {31'b0, mif.req_ready},  32'd0);
    check("rst_ren",        {31'b0, mif.bus_ren},    32'd0);
    check("rst_wen",        {31'b0, mif.bus_wen},    32'd0);
    check("rst_resp_valid", {31'b0, mif.resp_valid}, 32'd0);
    check("rst_bus_addr",   mif.bus_addr,            32'h0);
    rst = 1'b0;
    #1;
    check("rel_ready_low",  {31'b0, mif.req_ready},  32'd0);
    @(posedge clk);
    #1;
    check("rel_ready_high", {31'b0, mif.req_ready},  32'd1);
    $display("[TB] txn reset released, req_ready=%0b", mif.req_ready);

    // Word load
    mem_word = 32'hDEADBEEF;
    run_txn("word_load", 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, rd, er, cyc, rn, wn);
    check("wl_rdata", rd, 32'hDEADBEEF);
    check("wl_err",   {31'b0, er}, 32'd0);
    check("wl_ren_n", 32'(rn), 32'd1);
    check("wl_wen_n", 32'(wn), 32'd0);
    check("wl_addr",  ren_addr, 32'h8000_0010);

    // Byte loads, signed and unsigned
    mem_word = 32'h80112233;
    run_txn("sbyte_load", 1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, rd, er, cyc, rn, wn);
    check("sb_rdata", rd, 32'hFFFFFF80);
    check("sb_err",   {31'b0, er}, 32'd0);
    run_txn("ubyte_load", 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, rd, er, cyc, rn, wn);
    check("ub_rdata", rd, 32'h00000080);

    // Half loads on both half lanes
    run_txn("shalf_load", 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, rd, er, cyc, rn, wn);
    check("sh_rdata", rd, 32'hFFFF8011);
    run_txn("uhalf_load", 1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0, rd, er, cyc, rn, wn);
    check("uh_rdata", rd, 32'h00002233);

    // Size 11 behaves as a word
    mem_word = 32'h0BADF00D;
    run_txn("size3_load", 1'b0, 2'b11, 1'b1, 32'h0000_0040, 32'h0, rd, er, cyc, rn, wn);
    check("s3_rdata", rd, 32'h0BADF00D);

    // Byte store read-modify-write
    mem_word = 32'h11223344;
    run_txn("byte_store", 1'b1, 2'b00, 1'b0, 32'h1F80_0001, 32'h0000_00AB, rd, er, cyc, rn, wn);
    check("bs_ren_n",   32'(rn), 32'd1);
    check("bs_wen_n",   32'(wn), 32'd1);
    check("bs_wdata",   wen_data, 32'h1122AB44);
    check("bs_wr_word", wr_word,  32'h1122AB44);
    check("bs_addr",    ren_addr, 32'h1F80_0000);
    check("bs_rdata",   rd, 32'h0);
    check("bs_err",     {31'b0, er}, 32'd0);

    // Half store into the upper lane
    run_txn("half_store", 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_BEEF, rd, er, cyc, rn, wn);
    check("hs_wr_word", wr_word, 32'hBEEF3344);

    // Misaligned accesses: error in the cycle after the accept cycle, no strobes
    run_txn("misal_half", 1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, rd, er, cyc, rn, wn);
    check("mh_err",   {31'b0, er}, 32'd1);
    check("mh_cycle", 32'(cyc), 32'd2);
    check("mh_rdata", rd, 32'h0);
    check("mh_ren_n", 32'(rn), 32'd0);
    check("mh_wen_n", 32'(wn), 32'd0);
    run_txn("misal_word", 1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h1234_5678, rd, er, cyc, rn, wn);
    check("mw_err",   {31'b0, er}, 32'd1);
    check("mw_wen_n", 32'(wn), 32'd0);

    // Stale ack held high while a word store is accepted
    @(negedge clk);
    hold_ack = 1'b1;
    repeat (2) @(negedge clk);
    n = wen_pulses;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stale_wen_low", {31'b0, mif.bus_wen}, 32'd0);
    end
    hold_ack = 1'b0;
    wait_resp(rd, er, cyc);
    $display("[TB] txn stale_ack_store addr=0x00000100 wdata=0xcafef00d -> err=%0b wr_word=0x%08h", er, wr_word);
    check("stale_err",   {31'b0, er}, 32'd0);
    check("stale_wen_n", 32'(wen_pulses - n), 32'd1);
    check("stale_wdata", wr_word, 32'hCAFEF00D);

`ifdef MEM_MASTER_TIMEOUT_EN
    // Responder never acks: strobe held TMO cycles then error
    @(negedge clk);
    mute = 1'b1;
    h0 = ren_hi;
    run_txn("tmo_load", 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, rd, er, cyc, rn, wn);
    check("tmo_err",     {31'b0, er}, 32'd1);
    check("tmo_ren_len", 32'(ren_hi - h0), 32'(TMO));
    check("tmo_rdata",   rd, 32'h0);
    run_txn("tmo_rmw", 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_0055, rd, er, cyc, rn, wn);
    check("tmo_rmw_err",   {31'b0, er}, 32'd1);
    check("tmo_rmw_wen_n", 32'(wn), 32'd0);
    @(negedge clk);
    mute = 1'b0;
`endif

    // Asynchronous reset while the read strobe is waiting
    @(negedge clk);
    mute = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    n = 0;
    while (!mif.bus_ren && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("arst_ren_seen", {31'b0, mif.bus_ren}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ren",   {31'b0, mif.bus_ren},   32'd0);
    check("arst_wen",   {31'b0, mif.bus_wen},   32'd0);
    check("arst_ready", {31'b0, mif.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    mute = 1'b0;
    #1;
    check("arst_rel_ready_low", {31'b0, mif.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_rel_ready_high", {31'b0, mif.req_ready}, 32'd1);
    $display("[TB] txn async reset mid-read, req_ready=%0b after release", mif.req_ready);

    // Normal operation after the reset
    mem_word = 32'h5A5A_A5A5;
    run_txn("post_rst_load", 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, rd, er, cyc, rn, wn);
    check("pr_rdata", rd, 32'h5A5A_A5A5);

    // Protocol invariants over the whole run
    check("no_overlap",     {31'b0, overlap},     32'd0);
    check("no_rise_on_ack", {31'b0, rise_on_ack}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
